resistor_capacitor_high_pass_filter: RTL and testbench
======================================================

Name: resistor_capacitor_high_pass_filter

Overview:
- Discrete-audio RC high-pass stage, the complement of the team's RC low-pass: y[n] = alpha*(y[n-1] + x[n] - x[n-1]), with alpha = RC/(RC+dt) in Q16.
- Uses one serial shift-add multiplier instead of a DSP slice, so many instances fit alongside the low-pass stages in a MiSTer discrete chain.
- Consumes one sample per audio_clk_en and produces one sample plus a valid pulse 19 clocks later.

Parameters:
- SAMPLE_RATE, 48000, audio sample rate in Hz.
- R, 47000, resistance in ohms.
- C_35_SHIFTED, 1615, capacitance in farads <<< 35.
- Derived localparams: DELTA_T_32 = 2^32/SAMPLE_RATE; RC_32 = (R*C_35_SHIFTED)>>>3; ALPHA_Q16 = (RC_32<<<16)/(RC_32+DELTA_T_32), 17-bit unsigned, 64923 at defaults.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- audio_clk_en  in  1  sample strobe, one clk wide
- in  in  16  signed input sample
- out  out  16  signed filtered sample, held between updates
- out_valid  out  1  one-cycle pulse when out updates
- busy  out  1  high whenever state != IDLE
- overrun  out  1  one-cycle pulse when a pending sample is overwritten

Behaviour:
- Reset (asynchronous, active-high) clears the following and aborts any computation in progress:
  - outputs: out=0, out_valid=0, busy=0, overrun=0
  - internal state: x_prev=0, x_cur=0, acc=0, pending=0, state=IDLE
- State machine IDLE -> SUM -> MUL -> DONE -> IDLE. Let edge N be the edge that samples audio_clk_en in IDLE.
  - Edge N: x_cur <= in (or the pending sample if pending=1; clear pending); go to SUM.
  - Edge N+1 (SUM): d <= out + x_cur - x_prev, 18-bit signed, no overflow possible; acc <= 0; bit counter <= 0; go to MUL.
  - Edges N+2..N+18 (MUL, 17 iterations): LSB-first over ALPHA_Q16 bits, acc += (d <<< k) when alpha bit k is set. acc is 35-bit signed. On k=16 go to DONE.
  - Edge N+19 (DONE): out <= saturate16(acc >>> 16) (arithmetic shift = floor; clamp to [-32768, 32767]); x_prev <= x_cur; out_valid=1 for this cycle only; go to IDLE.
- Latency: exactly 19 clk from strobe edge to out update. Minimum clk/sample ratio is 20 for sustained throughput.
- audio_clk_en while busy:
  - Copy in to the pending register and set pending.
  - If pending was already set, overwrite it and pulse overrun.
- Pending service: IDLE with pending=1 starts a new computation on the next edge regardless of audio_clk_en.
  - If audio_clk_en is also high on that edge, the pending sample is processed and the new one becomes pending; overrun does not pulse.
- audio_clk_en in the DONE cycle goes to pending; it is never lost.
- out is stable except at the DONE edge. in is sampled only at capture edges.
- Saturation acts only on the final result. Internal widths are sized so d and acc never wrap.

Decomposition:
- Package discrete_filter_pkg holds:
  - state enum (IDLE, SUM, MUL, DONE)
  - Q16 constant ONE_Q16 = 65536
  - sample type: signed 16-bit
  - function saturate16 (35-bit signed -> 16-bit signed), reusable by other discrete stages
- One natural sub-module: serial_multiplier_17x18.
  - Inputs: start, 18-bit signed multiplicand, 17-bit unsigned multiplier.
  - Outputs: 35-bit product, done.
  - The filter FSM sequences it; the low-pass can adopt it later.

Test Plan:
- Step from rest, defaults: reset, then in=10000 on consecutive strobes (>=20 clk apart).
  - out = 9906, then 9813; out_valid exactly 19 clk after each strobe.
- Decay to zero: hold in=10000 for 3000 strobes -> out settles at 0; it never goes negative.
- Saturation:
  - Hold in=-32768 for 4000 strobes; out settles at -1 (floor fixed point).
  - Then one strobe with in=32767 -> out = 32767 (clamped), no wrap.
- Back-to-back strobes:
  - Strobe at cycle 0 (in=10000) and cycle 5 (in=10000) -> outputs 9906 at cycle 19 and 9813 at cycle 39.
  - A third strobe at cycle 6 and a fourth at cycle 7 -> overrun pulse at cycle 7; the cycle-7 sample is the one processed.
- Reset mid-MUL: assert reset at cycle 10 after a strobe.
  - out=0, busy=0 immediately, no out_valid.
  - After release, in=10000 strobe -> out = 9906.
- Strobe on the DONE edge: strobe lands exactly on cycle N+19.
  - It is held pending; processing starts at N+20 and output comes at N+39.

Source files
------------

// File: rtl/discrete_filter_pkg.sv
// Shared types and helpers for the discrete audio filter stages
// (RC high-pass, RC low-pass and related blocks).
package discrete_filter_pkg;

   typedef enum logic [1:0] {IDLE, SUM, MUL, DONE} state_t;

   localparam longint ONE_Q16 = 65536;

   typedef logic signed [15:0] sample_t;

   // Clamp a wide signed result to the 16-bit audio range.
   function automatic sample_t saturate16(input logic signed [34:0] v);
      sample_t r;
      if (v > 35'sd32767)
         r = 16'h7fff;
      else if (v < -35'sd32768)
         r = 16'h8000;
      else
         r = v[15:0];
      return r;
   endfunction

endpackage

// File: rtl/resistor_capacitor_high_pass_filter_if.sv
// Sample-stream bus of the RC high-pass stage: strobe and sample in,
// filtered sample and status out.
interface resistor_capacitor_high_pass_filter_if;
   import discrete_filter_pkg::*;

   logic    i_audio_clk_en;
   sample_t i_in;
   sample_t o_out;
   logic    o_out_valid;
   logic    o_busy;
   logic    o_overrun;

   modport master (
      output i_audio_clk_en, i_in,
      input  o_out, o_out_valid, o_busy, o_overrun
   );

   modport slave (
      input  i_audio_clk_en, i_in,
      output o_out, o_out_valid, o_busy, o_overrun
   );
endinterface

// File: rtl/serial_multiplier_17x18.sv
// LSB-first shift-add multiplier: 18-bit signed x 17-bit unsigned -> 35-bit
// signed, one multiplier bit per clock, 17 clocks after start.
module serial_multiplier_17x18 (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_start,
   input  logic signed [17:0] i_mcand,
   input  logic        [16:0] i_mplier,
   output logic signed [34:0] o_product,
   output logic               o_done
);

   logic signed [17:0] r_mcand;
   logic        [16:0] r_mplier;
   logic signed [34:0] r_acc;
   logic        [4:0]  r_k;
   logic               r_run;
   logic signed [34:0] w_addend;

   // Sign-extend first so the shifted partial product keeps its sign.
   assign w_addend = {{17{r_mcand[17]}}, r_mcand} <<< r_k;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_k      <= '0;
         r_run    <= 1'b0;
      end else if (i_start) begin
         r_mcand  <= i_mcand;
         r_mplier <= i_mplier;
         r_acc    <= '0;
         r_k      <= '0;
         r_run    <= 1'b1;
      end else if (r_run) begin
         if (r_mplier[r_k])
            r_acc <= r_acc + w_addend;
         if (r_k == 5'd16)
            r_run <= 1'b0;
         else
            r_k <= r_k + 5'd1;
      end
   end

   assign o_product = r_acc;
   assign o_done    = r_run && (r_k == 5'd16);

endmodule

// File: rtl/resistor_capacitor_high_pass_filter.sv
// Discrete RC high-pass: y[n] = alpha*(y[n-1] + x[n] - x[n-1]), alpha in Q16,
// computed with a serial multiplier; result 19 clocks after the strobe.
module resistor_capacitor_high_pass_filter
   import discrete_filter_pkg::*;
#(
   parameter int SAMPLE_RATE  = 48000,
   parameter int R            = 47000,
   parameter int C_35_SHIFTED = 1615
) (
   input logic clk,
   input logic reset,
   resistor_capacitor_high_pass_filter_if.slave bus
);

   localparam longint DELTA_T_32 = 64'sh1_0000_0000 / longint'(SAMPLE_RATE);
   localparam longint RC_32      = (longint'(R) * longint'(C_35_SHIFTED)) >>> 3;
   localparam longint ALPHA_L    = (RC_32 * ONE_Q16) / (RC_32 + DELTA_T_32);
   localparam logic [16:0] ALPHA_Q16 = ALPHA_L[16:0];

   state_t             r_state, w_state_nxt;
   sample_t            r_x_cur, r_x_prev, r_pend_smp, r_out;
   logic               r_pending, r_out_valid, r_overrun;
   logic               w_capture, w_mul_start, w_mul_done;
   logic signed [17:0] w_d;
   logic signed [34:0] w_prod, w_scaled;

   // |out| + |x_cur - x_prev| stays below 2^17, so 18 bits never wrap.
   assign w_d = {{2{r_out[15]}}, r_out} + {{2{r_x_cur[15]}}, r_x_cur}
              - {{2{r_x_prev[15]}}, r_x_prev};
   assign w_scaled  = w_prod >>> 16;
   assign w_capture = (r_state == IDLE) && (bus.i_audio_clk_en || r_pending);

   serial_multiplier_17x18 u_mul (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_mul_start),
      .i_mcand  (w_d),
      .i_mplier (ALPHA_Q16),
      .o_product(w_prod),
      .o_done   (w_mul_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mul_start = 1'b0;
      case (r_state)
         IDLE: if (w_capture) w_state_nxt = SUM;
         SUM: begin
            w_mul_start = 1'b1;
            w_state_nxt = MUL;
         end
         MUL:  if (w_mul_done) w_state_nxt = DONE;
         DONE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x_cur     <= '0;
         r_x_prev    <= '0;
         r_pend_smp  <= '0;
         r_pending   <= 1'b0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
         if (w_capture) begin
            r_x_cur <= r_pending ? r_pend_smp : bus.i_in;
            // A strobe landing while the pending sample is taken replaces it.
            if (r_pending) begin
               if (bus.i_audio_clk_en)
                  r_pend_smp <= bus.i_in;
               else
                  r_pending <= 1'b0;
            end
         end else if (bus.i_audio_clk_en && (r_state != IDLE)) begin
            r_pend_smp <= bus.i_in;
            r_pending  <= 1'b1;
            r_overrun  <= r_pending;
         end
         if (r_state == DONE) begin
            r_out       <= saturate16(w_scaled);
            r_x_prev    <= r_x_cur;
            r_out_valid <= 1'b1;
         end
      end
   end

   assign bus.o_out       = r_out;
   assign bus.o_out_valid = r_out_valid;
   assign bus.o_busy      = (r_state != IDLE);
   assign bus.o_overrun   = r_overrun;

endmodule

// File: tb/tb_resistor_capacitor_high_pass_filter.sv
// Self-checking bench for the RC high-pass stage against an arithmetic model.
module tb_resistor_capacitor_high_pass_filter;
   import discrete_filter_pkg::*;

   localparam int SAMPLE_RATE  = 48000;
   localparam int R            = 47000;
   localparam int C_35_SHIFTED = 1615;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   resistor_capacitor_high_pass_filter_if u_if ();

   resistor_capacitor_high_pass_filter #(
      .SAMPLE_RATE (SAMPLE_RATE),
      .R           (R),
      .C_35_SHIFTED(C_35_SHIFTED)
   ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (u_if.slave)
   );

   always #5 clk = ~clk;

   int     n_chk = 0;
   int     n_err = 0;
   int     n_ovr = 0;
   int     n_vld = 0;
   longint alpha;
   longint m_y  = 0;
   longint m_xp = 0;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      n_ovr += int'(u_if.o_overrun);
      n_vld += int'(u_if.o_out_valid);
   endtask

   function automatic longint floor_div(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0)))
         q = q - 1;
      return q;
   endfunction

   task automatic model_step(input longint x);
      longint v;
      v = floor_div((m_y + x - m_xp) * alpha, 65536);
      if (v > 32767)
         v = 32767;
      else if (v < -32768)
         v = -32768;
      m_y  = v;
      m_xp = x;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!u_if.o_out_valid && n < 60);
   endtask

   task automatic run_sample(input sample_t x, output int lat);
      u_if.i_in           = x;
      u_if.i_audio_clk_en = 1'b1;
      tick();
      u_if.i_audio_clk_en = 1'b0;
      wait_valid(lat);
      model_step(x);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      m_y  = 0;
      m_xp = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int      lat, n, neg, ov0, v0;
      longint  prev;
      sample_t a, b, c;
      longint  dt, rc;

      u_if.i_audio_clk_en = 1'b0;
      u_if.i_in           = '0;
      dt    = (longint'(1) << 32) / SAMPLE_RATE;
      rc    = (longint'(R) * C_35_SHIFTED) / 8;
      alpha = (rc * 65536) / (rc + dt);

      tick();
      tick();
      chk("rst_out", u_if.o_out, 0);
      chk("rst_valid", u_if.o_out_valid, 0);
      chk("rst_busy", u_if.o_busy, 0);
      chk("rst_overrun", u_if.o_overrun, 0);
      reset = 1'b0;

      // Step from rest
      run_sample(16'sd10000, lat);
      chk("step1_lat", lat, 19);
      chk("step1_out", u_if.o_out, 9906);
      chk("step1_model", u_if.o_out, m_y);
      tick();
      chk("step1_pulse", u_if.o_out_valid, 0);
      chk("step1_hold", u_if.o_out, 9906);
      chk("step1_idle", u_if.o_busy, 0);
      run_sample(16'sd10000, lat);
      chk("step2_lat", lat, 19);
      chk("step2_out", u_if.o_out, 9813);

      // Decay to zero at the minimum 20-clock sample spacing
      neg = 0;
      for (int i = 0; i < 1100; i++) begin
         run_sample(16'sd10000, lat);
         chk("decay_lat", lat, 19);
         chk("decay_out", u_if.o_out, m_y);
         if (u_if.o_out < 0) neg++;
      end
      chk("decay_final", u_if.o_out, 0);
      chk("decay_negative", neg, 0);

      // Negative full scale, then a positive full-scale jump
      prev = 0;
      for (int i = 0; i < 1300; i++) begin
         prev = longint'(u_if.o_out);
         run_sample(-16'sd32768, lat);
         chk("sat_lat", lat, 19);
         chk("sat_out", u_if.o_out, m_y);
      end
      chk("sat_settled", u_if.o_out, prev);
      run_sample(16'sd32767, lat);
      chk("sat_clamp", u_if.o_out, 32767);

      // Random samples with random idle gaps
      for (int i = 0; i < 40; i++) begin
         a = sample_t'($urandom());
         run_sample(a, lat);
         chk("rand_lat", lat, 19);
         chk("rand_out", u_if.o_out, m_y);
         repeat ($urandom_range(0, 5)) tick();
      end

      // Back-to-back: strobes at cycles 0 and 5
      do_reset();
      u_if.i_in = 16'sd10000;
      u_if.i_audio_clk_en = 1'b1;
      tick();
      u_if.i_audio_clk_en = 1'b0;
      repeat (4) tick();
      u_if.i_audio_clk_en = 1'b1;
      tick();
      u_if.i_audio_clk_en = 1'b0;
      wait_valid(n);
      chk("b2b_first_lat", n + 5, 19);
      chk("b2b_first_out", u_if.o_out, 9906);
      wait_valid(n);
      chk("b2b_second_lat", n, 20);
      chk("b2b_second_out", u_if.o_out, 9813);
      model_step(10000);
      model_step(10000);

      // Overrun: strobes at 0, 6, 7; the cycle-7 sample wins
      a = sample_t'($urandom());
      b = sample_t'($urandom());
      c = sample_t'($urandom());
      ov0 = n_ovr;
      u_if.i_in = a;
      u_if.i_audio_clk_en = 1'b1;
      tick();
      u_if.i_audio_clk_en = 1'b0;
      repeat (5) tick();
      u_if.i_in = b;
      u_if.i_audio_clk_en = 1'b1;
      tick();
      chk("ovr_c6", u_if.o_overrun, 0);
      u_if.i_in = c;
      tick();
      chk("ovr_c7", u_if.o_overrun, 1);
      u_if.i_audio_clk_en = 1'b0;
      wait_valid(n);
      chk("ovr_first_lat", n + 7, 19);
      model_step(a);
      chk("ovr_first_out", u_if.o_out, m_y);
      wait_valid(n);
      chk("ovr_second_lat", n, 20);
      model_step(c);
      chk("ovr_second_out", u_if.o_out, m_y);
      chk("ovr_count", n_ovr - ov0, 1);

      // Pending served while a new strobe arrives in IDLE
      a = sample_t'($urandom());
      b = sample_t'($urandom());
      c = sample_t'($urandom());
      ov0 = n_ovr;
      u_if.i_in = a;
      u_if.i_audio_clk_en = 1'b1;
      tick();
      u_if.i_audio_clk_en = 1'b0;
      repeat (4) tick();
      u_if.i_in = b;
      u_if.i_audio_clk_en = 1'b1;
      tick();
      u_if.i_audio_clk_en = 1'b0;
      repeat (14) tick();
      chk("pend_first_vld", u_if.o_out_valid, 1);
      model_step(a);
      chk("pend_first_out", u_if.o_out, m_y);
      u_if.i_in = c;
      u_if.i_audio_clk_en = 1'b1;
      tick();
      u_if.i_audio_clk_en = 1'b0;
      chk("pend_no_ovr", u_if.o_overrun, 0);
      wait_valid(n);
      chk("pend_second_lat", n, 19);
      model_step(b);
      chk("pend_second_out", u_if.o_out, m_y);
      wait_valid(n);
      chk("pend_third_lat", n, 20);
      model_step(c);
      chk("pend_third_out", u_if.o_out, m_y);
      chk("pend_ovr_count", n_ovr - ov0, 0);

      // Strobe landing on the DONE edge
      a = sample_t'($urandom());
      b = sample_t'($urandom());
      u_if.i_in = a;
      u_if.i_audio_clk_en = 1'b1;
      tick();
      u_if.i_audio_clk_en = 1'b0;
      repeat (18) tick();
      u_if.i_in = b;
      u_if.i_audio_clk_en = 1'b1;
      tick();
      u_if.i_audio_clk_en = 1'b0;
      chk("done_edge_vld", u_if.o_out_valid, 1);
      model_step(a);
      chk("done_edge_out", u_if.o_out, m_y);
      chk("done_edge_idle", u_if.o_busy, 0);
      wait_valid(n);
      chk("done_edge_lat", n, 20);
      model_step(b);
      chk("done_edge_next", u_if.o_out, m_y);

      // Reset in the middle of the multiply
      v0 = n_vld;
      u_if.i_in = 16'sd10000;
      u_if.i_audio_clk_en = 1'b1;
      tick();
      u_if.i_audio_clk_en = 1'b0;
      repeat (10) tick();
      chk("mid_busy_before", u_if.o_busy, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_out", u_if.o_out, 0);
      chk("mid_rst_busy", u_if.o_busy, 0);
      chk("mid_rst_valid", u_if.o_out_valid, 0);
      tick();
      tick();
      reset = 1'b0;
      m_y  = 0;
      m_xp = 0;
      repeat (25) tick();
      chk("mid_rst_no_valid", n_vld - v0, 0);
      run_sample(16'sd10000, lat);
      chk("mid_rst_lat", lat, 19);
      chk("mid_rst_out_after", u_if.o_out, 9906);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
